mcp23s17_spi_responder: RTL and testbench
=========================================

// Module: mcp23s17_spi_responder
// PURPOSE
// SPI responder that emulates a Microchip MCP23S17 16-bit GPIO expander (IOCON.BANK=0 register map).
// It is the far end of the gpio_spi joystick link: it presents 16 pins, a register file and an
// interrupt line, so gpio_spi can be exercised in loop-back and a second board can expose pad
// state to it. All logic runs on CLK; the SPI inputs are oversampled.
// PARAMETERS
// SYNC_STAGES   2        synchronizer depth for SPI_SCK, SPI_CS_N, SPI_MOSI and GPIO_IN
// IODIR_RESET   16'hFFFF reset value of {IODIRB,IODIRA}; 1 = input
// PORTS
// CLK          in   1   system clock; must be >= 8x the SPI_SCK frequency
// RESET_N      in   1   asynchronous active-low reset
// SPI_SCK      in   1   SPI clock, mode 0 (CPOL=0, CPHA=0)
// SPI_CS_N     in   1   chip select, active low; frames a transaction
// SPI_MOSI     in   1   serial data in, MSB first
// SPI_MISO     out  1   serial data out, MSB first
// SPI_MISO_OE  out  1   1 = drive MISO (read data phase of an addressed frame only)
// HW_ADDR      in   3   A2..A0 strap, compared only when IOCON.HAEN=1
// GPIO_IN      in   16  pin levels {B[7:0],A[7:0]}
// GPIO_OUT     out  16  {OLATB,OLATA}
// GPIO_DIR     out  16  {IODIRB,IODIRA}; 1 = input
// INTA         out  1   interrupt output (mirrored: ports A and B), polarity set by IOCON.INTPOL
// BEHAVIOUR
// Reset: IODIR=IODIR_RESET; all other registers 0; SPI_MISO=0; SPI_MISO_OE=0; INTA=1 (inactive); FSM in IDLE.
// Register map (hex): IODIR 00/01, IPOL 02/03, GPINTEN 04/05, DEFVAL 06/07, INTCON 08/09,
//   IOCON 0A/0B (one shared register), GPPU 0C/0D, INTF 0E/0F (RO), INTCAP 10/11 (RO),
//   GPIO 12/13, OLAT 14/15. Addresses 16..FF read 0x00; writes to them are ignored.
// IOCON: bit7 BANK reads 0 and is not settable; bit5 SEQOP; bit3 HAEN; bit1 INTPOL; other bits are stored only.
// SPI sampling: MOSI is sampled on the synchronized SCK rising edge. MISO changes on the SCK falling
//   edge. The MSB of each read byte is valid before that byte's first rising edge.
// FSM: IDLE -> OPCODE on CS_N fall. OPCODE collects 8 bits, then:
//   - go to ADDR if opcode[7:4]==4'b0100 and (HAEN==0 or opcode[3:1]==HW_ADDR);
//   - otherwise go to IGNORE, which holds until CS_N rises.
//   ADDR collects 8 bits into the address pointer, then goes to WDATA if opcode[0]==0, RDATA if opcode[0]==1.
// WDATA: every 8th bit commits the byte to the pointed register in the same CLK cycle. The pointer
//   then advances if SEQOP==0; 15h wraps to 00h. Writes to GPIO write OLAT. Writes to INTF/INTCAP are dropped.
// RDATA: the read value is loaded into the shift register on the ADDR/RDATA 8th rising edge and
//   after each read byte; the pointer advances as in WDATA. SPI_MISO_OE=1 only in RDATA.
// GPIO read value: the input bits return sync(GPIO_IN) XOR IPOL; the output bits return OLAT.
// CS_N rise in any state: return to IDLE; discard a partial byte; MISO_OE=0 on the next CLK.
//   A complete byte before the rise is already committed.
// Interrupts, per bit i: enabled when GPINTEN[i] & IODIR[i].
//   - Event condition, INTCON[i]=0: pin differs from its previous synchronized sample.
//   - Event condition, INTCON[i]=1: pin differs from DEFVAL[i].
//   - If the port's INTF==0 and any event fires: set INTF for the firing bits and capture INTCAP=pin values,
//     one CLK after the change reaches the synchronizer output.
//   - While a port's INTF!=0, further events on that port are ignored.
//   - A completed read byte of GPIO or INTCAP of a port clears that port's INTF.
//   - If a clear and a new event occur in the same cycle, the set wins and INTCAP updates.
// INTA = (INTFA|INTFB)!=0 ? INTPOL : ~INTPOL, registered.
// A config write and a pin event in the same cycle: the event uses the old config; the new config applies from the next cycle.
// Async reset mid-frame: everything returns to reset values immediately; the frame is lost.
// TESTING
// Write 40 0A 28 then 40 00 00 (HAEN=1, SEQOP=1; HW_ADDR=0) -> IOCON=28h, IODIRA=00, GPIO_DIR[7:0]=00.
// Sequential write 40 14 A5 3C, then read 41 14 xx xx -> GPIO_OUT=3CA5; MISO returns A5, 3C; MISO_OE high only on the data bytes.
// HAEN=1, HW_ADDR=3, opcode 40 -> frame ignored, MISO_OE stays 0, registers unchanged; opcode 46 -> accepted.
// GPINTENA=01, INTCONA=0, toggle GPIO_IN[0] 0->1 -> INTFA=01, INTCAPA bit0=1, INTA=0;
//   read 41 10 -> INTA=1 after the byte completes.
// INTCONB=FF, DEFVALB=00, GPINTENB=80, GPIO_IN[15]=1 -> INTFB=80; a 2nd pin change before clearing leaves INTCAPB unchanged.
// CS_N rises after 5 data bits of a write to OLATA -> OLATA keeps its old value; the next frame decodes normally.
// Read address 20h -> MISO returns 00; wrap test: SEQOP=0, read from 15h for 2 bytes -> OLATB then IODIRA.

Source files
------------

// File: rtl/mcp23s17_spi_responder.sv
// MCP23S17 (IOCON.BANK=0) emulation: oversampled mode-0 SPI slave, register file and interrupt logic.
// All SPI and pin inputs are synchronized into clk; SPI edges are detected on the synchronized SCK.
module mcp23s17_spi_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] IODIR_RESET = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [2:0]  hw_addr,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [15:0] gpio_dir,
  output logic        inta
);

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic [15:0] gpio_sync [SYNC_STAGES];
  logic sck_s, cs_s, mosi_s, sck_q, cs_q;
  logic [15:0] gpio_s, gpio_prev;

  logic [15:0] iodir, ipol, gpinten, defval, intcon, gppu, intf, intcap, olat;
  logic [7:0]  iocon;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out, addr_ptr, next_ptr, rd_addr, rd_data, new_byte;
  logic [15:0] rd_word, gpio_rd, event_bits;
  logic [3:0]  lane;
  logic [1:0]  clear_int;
  logic        rd_not_wr, sck_rise, sck_fall, cs_fall, shifting, byte_done;
  logic        opcode_ok, wr_en, rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) gpio_sync[i] <= '0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      gpio_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) gpio_sync[i] <= gpio_sync[i-1];
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign gpio_s    = gpio_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_q;
  assign sck_fall  = ~sck_s & sck_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign shifting  = (state == OPCODE) || (state == ADDR) || (state == WDATA) || (state == RDATA);
  assign byte_done = shifting && sck_rise && (bit_cnt == 3'd7);
  assign new_byte  = {shift_in, mosi_s};
  assign opcode_ok = (new_byte[7:4] == 4'b0100) && (!iocon[3] || (new_byte[3:1] == hw_addr));
  assign wr_en     = (state == WDATA) && byte_done;
  assign rd_done   = (state == RDATA) && byte_done;
  assign next_ptr  = iocon[5] ? addr_ptr : ((addr_ptr == 8'h15) ? 8'h00 : addr_ptr + 8'd1);
  assign rd_addr   = (state == ADDR) ? new_byte : next_ptr;
  assign lane      = {addr_ptr[0], 3'b000};
  assign gpio_rd   = (iodir & (gpio_s ^ ipol)) | (~iodir & olat);
  assign gpio_out  = olat;
  assign gpio_dir  = iodir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // CS_N high aborts any frame, including one held in IGNORE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = OPCODE;
      OPCODE:  if (byte_done) state_next = opcode_ok ? ADDR : IGNORE;
      ADDR:    if (byte_done) state_next = rd_not_wr ? RDATA : WDATA;
      default: ;
    endcase
    if (cs_s) state_next = IDLE;
  end

  always_comb begin
    rd_word = '0;
    case (rd_addr[7:1])
      7'h00:   rd_word = iodir;
      7'h01:   rd_word = ipol;
      7'h02:   rd_word = gpinten;
      7'h03:   rd_word = defval;
      7'h04:   rd_word = intcon;
      7'h05:   rd_word = {iocon, iocon};
      7'h06:   rd_word = gppu;
      7'h07:   rd_word = intf;
      7'h08:   rd_word = intcap;
      7'h09:   rd_word = gpio_rd;
      7'h0A:   rd_word = olat;
      default: rd_word = '0;
    endcase
    rd_data = rd_addr[0] ? rd_word[15:8] : rd_word[7:0];
  end

  // Next read byte is loaded on the completing rising edge; MISO then shifts on each falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      addr_ptr    <= '0;
      rd_not_wr   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= (state_next == RDATA);
      if (state == IDLE) begin
        bit_cnt  <= '0;
        spi_miso <= 1'b0;
      end else if (shifting && sck_rise) begin
        shift_in <= new_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end else if ((state == RDATA) && sck_fall) begin
        spi_miso  <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end
      if (byte_done) begin
        case (state)
          OPCODE: rd_not_wr <= new_byte[0];
          ADDR: begin
            addr_ptr  <= new_byte;
            shift_out <= rd_data;
          end
          WDATA: addr_ptr <= next_ptr;
          RDATA: begin
            addr_ptr  <= next_ptr;
            shift_out <= rd_data;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iodir   <= IODIR_RESET;
      ipol    <= '0;
      gpinten <= '0;
      defval  <= '0;
      intcon  <= '0;
      iocon   <= '0;
      gppu    <= '0;
      olat    <= '0;
    end else if (wr_en) begin
      case (addr_ptr[7:1])
        7'h00:        iodir[lane +: 8]   <= new_byte;
        7'h01:        ipol[lane +: 8]    <= new_byte;
        7'h02:        gpinten[lane +: 8] <= new_byte;
        7'h03:        defval[lane +: 8]  <= new_byte;
        7'h04:        intcon[lane +: 8]  <= new_byte;
        7'h05:        iocon              <= {1'b0, new_byte[6:0]};
        7'h06:        gppu[lane +: 8]    <= new_byte;
        7'h09, 7'h0A: olat[lane +: 8]    <= new_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    clear_int = '0;
    if (rd_done && ((addr_ptr[7:1] == 7'h08) || (addr_ptr[7:1] == 7'h09)))
      clear_int[addr_ptr[0]] = 1'b1;
  end

  assign event_bits = gpinten & iodir &
                      ((intcon & (gpio_s ^ defval)) | (~intcon & (gpio_s ^ gpio_prev)));

  // A new event in the same cycle as a read-clear re-arms the flag and recaptures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intf      <= '0;
      intcap    <= '0;
      gpio_prev <= '0;
      inta      <= 1'b1;
    end else begin
      gpio_prev <= gpio_s;
      inta      <= (|intf) ? iocon[1] : ~iocon[1];
      for (int p = 0; p < 2; p++) begin
        if (((intf[p*8 +: 8] == 8'h00) || clear_int[p]) && (event_bits[p*8 +: 8] != 8'h00)) begin
          intf[p*8 +: 8]   <= event_bits[p*8 +: 8];
          intcap[p*8 +: 8] <= gpio_s[p*8 +: 8];
        end else if (clear_int[p]) begin
          intf[p*8 +: 8] <= 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcp23s17_spi_responder.sv
// Bench for mcp23s17_spi_responder: directed and random SPI frames against a register-level model;
// read bytes are queued at issue time and compared by an independent MISO monitor.
module tb_mcp23s17_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [2:0]  hw_addr = 3'd0;
  logic [15:0] gpio_in = 16'h0000;
  logic        spi_miso, spi_miso_oe, inta;
  logic [15:0] gpio_out, gpio_dir;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  exp_q [$];
  logic [15:0] m [11];
  logic [7:0]  m_iocon;
  logic [15:0] m_pins = 16'h0000;

  always #5 clk = ~clk;

  mcp23s17_spi_responder #(.SYNC_STAGES(2), .IODIR_RESET(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .hw_addr(hw_addr), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .inta(inta)
  );

  function automatic void mReset();
    for (int k = 0; k < 11; k++) m[k] = 16'h0000;
    m[0] = 16'hFFFF;
    m_iocon = 8'h00;
  endfunction

  function automatic logic [7:0] mRead(input logic [7:0] a);
    logic [15:0] w;
    if (a > 8'h15) return 8'h00;
    case (int'(a[7:1]))
      5:       w = {m_iocon, m_iocon};
      9:       for (int i = 0; i < 16; i++) w[i] = m[0][i] ? (m_pins[i] ^ m[1][i]) : m[10][i];
      default: w = m[int'(a[7:1])];
    endcase
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic void mWrite(input logic [7:0] a, input logic [7:0] v);
    int k;
    int lane;
    k = int'(a[7:1]);
    lane = a[0] ? 8 : 0;
    if (a > 8'h15) return;
    case (k)
      5:       m_iocon = {1'b0, v[6:0]};
      7, 8:    ;
      9, 10:   m[10][lane +: 8] = v;
      default: m[k][lane +: 8] = v;
    endcase
  endfunction

  function automatic void mEval(input logic [15:0] changed);
    logic [15:0] ev;
    ev = m[2] & m[0] & ((m[4] & (m_pins ^ m[3])) | (~m[4] & changed));
    for (int p = 0; p < 2; p++) begin
      if (m[7][p*8 +: 8] == 8'h00 && ev[p*8 +: 8] != 8'h00) begin
        m[7][p*8 +: 8] = ev[p*8 +: 8];
        m[8][p*8 +: 8] = m_pins[p*8 +: 8];
      end
    end
  endfunction

  task automatic sendBit(input logic b);
    spi_sck = 1'b0;
    spi_mosi = b;
    #50;
    spi_sck = 1'b1;
    #50;
  endtask

  task automatic spiDrive(input logic [7:0] b [8], input int n, input int extra);
    @(negedge clk);
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < n; i++)
      for (int j = 7; j >= 0; j--) sendBit(b[i][j]);
    for (int j = 0; j < extra; j++) sendBit(b[n][7-j]);
    spi_sck = 1'b0;
    #50;
    spi_cs_n = 1'b1;
    #300;
  endtask

  task automatic applyStimulus(input logic [7:0] b [8], input int n, input int extra);
    logic [7:0] ptr;
    logic seq;
    int lane;
    if (n >= 2 && b[0][7:4] == 4'b0100 && (!m_iocon[3] || b[0][3:1] == hw_addr)) begin
      ptr = b[1];
      for (int i = 2; i < n; i++) begin
        seq = m_iocon[5];
        lane = ptr[0] ? 8 : 0;
        if (b[0][0]) begin
          exp_q.push_back(mRead(ptr));
          if (ptr >= 8'h10 && ptr <= 8'h13) begin
            m[7][lane +: 8] = 8'h00;
            mEval(16'h0000);
          end
        end else begin
          mWrite(ptr, b[i]);
          mEval(16'h0000);
        end
        if (!seq) ptr = (ptr == 8'h15) ? 8'h00 : ptr + 8'd1;
      end
    end
    spiDrive(b, n, extra);
  endtask

  task automatic send(input logic [7:0] b0, b1, b2, b3, input int n, input int extra);
    logic [7:0] fr [8];
    fr = '{b0, b1, b2, b3, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(fr, n, extra);
  endtask

  task automatic setPins(input logic [15:0] v);
    logic [15:0] changed;
    changed = v ^ m_pins;
    m_pins = v;
    gpio_in = v;
    mEval(changed);
    #100;
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    logic exp_inta;
    exp_inta = (m[7] != 16'h0000) ? m_iocon[1] : ~m_iocon[1];
    checkVal({name, "_gpio_out"}, gpio_out, m[10]);
    checkVal({name, "_gpio_dir"}, gpio_dir, m[0]);
    checkVal({name, "_inta"}, {15'h0000, inta}, {15'h0000, exp_inta});
  endtask

  // MISO monitor: assembles bytes while OE is high and scores them against the queue.
  int         mcnt = 0;
  logic [7:0] mbyte = 8'h00;
  logic [7:0] mexp;
  always @(posedge spi_sck or negedge spi_cs_n) begin
    if (!spi_cs_n) begin
      if (!spi_sck) begin
        mcnt = 0;
      end else if (spi_miso_oe) begin
        mbyte = {mbyte[6:0], spi_miso};
        mcnt++;
        if (mcnt == 8) begin
          mcnt = 0;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_read: got %02h expected no read data", mbyte);
          end else begin
            mexp = exp_q.pop_front();
            if (mbyte !== mexp) begin
              miscompares++;
              $display("[TB] FAIL miso_byte: got %02h expected %02h", mbyte, mexp);
            end
          end
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] fr [8];
    int r;
    int n;
    mReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #100;
    checkOutput("reset");
    checkVal("reset_miso", {15'h0000, spi_miso}, 16'h0000);
    checkVal("reset_miso_oe", {15'h0000, spi_miso_oe}, 16'h0000);

    send(8'h40, 8'h0A, 8'h28, 8'h00, 3, 0);
    send(8'h40, 8'h00, 8'h00, 8'h00, 3, 0);
    checkOutput("config");
    send(8'h41, 8'h0A, 8'h00, 8'h00, 3, 0);

    send(8'h40, 8'h0A, 8'h08, 8'h00, 3, 0);
    send(8'h40, 8'h14, 8'hA5, 8'h3C, 4, 0);
    send(8'h41, 8'h14, 8'h00, 8'h00, 4, 0);
    checkOutput("seq_write");

    hw_addr = 3'd3;
    send(8'h40, 8'h14, 8'h11, 8'h00, 3, 0);
    send(8'h41, 8'h14, 8'h00, 8'h00, 3, 0);
    checkOutput("haen_reject");
    send(8'h46, 8'h14, 8'h22, 8'h00, 3, 0);
    send(8'h47, 8'h14, 8'h00, 8'h00, 3, 0);
    checkOutput("haen_accept");

    send(8'h46, 8'h00, 8'hFF, 8'h00, 3, 0);
    send(8'h46, 8'h04, 8'h01, 8'h00, 3, 0);
    send(8'h46, 8'h08, 8'h00, 8'h00, 3, 0);
    setPins(16'h0001);
    checkOutput("inta_set");
    send(8'h47, 8'h0E, 8'h00, 8'h00, 3, 0);
    send(8'h47, 8'h10, 8'h00, 8'h00, 3, 0);
    checkOutput("inta_clear");

    send(8'h46, 8'h09, 8'hFF, 8'h00, 3, 0);
    send(8'h46, 8'h07, 8'h00, 8'h00, 3, 0);
    send(8'h46, 8'h05, 8'h80, 8'h00, 3, 0);
    setPins(16'h8001);
    send(8'h47, 8'h0F, 8'h00, 8'h00, 3, 0);
    setPins(16'h8101);
    send(8'h47, 8'h11, 8'h00, 8'h00, 3, 0);
    send(8'h47, 8'h11, 8'h00, 8'h00, 3, 0);
    checkOutput("defval_int");

    send(8'h46, 8'h14, 8'h5A, 8'h00, 2, 5);
    checkOutput("partial_write");
    send(8'h46, 8'h14, 8'h77, 8'h00, 3, 0);
    checkOutput("after_partial");

    send(8'h47, 8'h20, 8'h00, 8'h00, 3, 0);
    send(8'h47, 8'h15, 8'h00, 8'h00, 4, 0);

    send(8'h46, 8'h00, 8'h0F, 8'h00, 3, 0);
    @(negedge clk);
    spi_cs_n = 1'b0;
    #100;
    for (int j = 0; j < 5; j++) sendBit(j[0]);
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
    spi_sck = 1'b0;
    #50;
    spi_cs_n = 1'b1;
    #300;
    mReset();
    checkOutput("async_reset");

    hw_addr = 3'd5;
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      fr[0] = {4'b0100, ($urandom_range(0, 5) == 0) ? 3'($urandom) : hw_addr, 1'b0};
      if ($urandom_range(0, 7) == 0) fr[0] = 8'($urandom) & 8'hFE;
      fr[1] = ($urandom_range(0, 7) == 0) ? 8'h20 + 8'($urandom_range(0, 200)) : 8'($urandom_range(0, 23));
      for (int i = 2; i < 8; i++) fr[i] = 8'($urandom);
      if (r <= 1) begin
        setPins(16'($urandom));
      end else if (r <= 5) begin
        n = 2 + $urandom_range(1, 3);
        applyStimulus(fr, n, 0);
      end else if (r <= 8) begin
        fr[0][0] = 1'b1;
        applyStimulus(fr, 3, 0);
      end else begin
        n = $urandom_range(2, 3);
        applyStimulus(fr, n, $urandom_range(1, 7));
      end
      checkOutput("random");
    end

    #200;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL missing_reads: got %0d bytes outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
